// File: rtl/serdes_pkg.sv
// Shared definitions for the serdes gearboxes: TMDS control symbols and
// buffer sizing helpers used by both the transmit and receive directions.
package serdes_pkg;

    localparam int unsigned TMDS_SYM_W = 10;

    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_11 = 10'h2AB;

    // Shift buffer must hold one full input word on top of a partial output slice.
    function automatic int unsigned buf_width(input int unsigned in_w, input int unsigned out_w);
        return in_w + out_w;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned in_w, input int unsigned out_w);
        return $clog2(in_w + out_w + 1);
    endfunction

endpackage

// File: rtl/serdes_gearbox_tx_rst_bridge.sv
// Reset bridge: asserts asynchronously, releases synchronously after two clock edges.
module rst_bridge (
    input  logic clk,
    input  logic arst,
    output logic rst_sync
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_sync = sync_q[1];

endmodule

// File: rtl/serdes_gearbox_tx.sv
// Multi-lane transmit gearbox: IN_W-bit words in via valid/ready, OUT_W-bit
// slices out LSB first, with training-word insertion and sticky underrun flag.
module serdes_gearbox_tx
    import serdes_pkg::*;
#(
    parameter int unsigned     CHANNELS   = 3,
    parameter int unsigned     IN_W       = 10,
    parameter int unsigned     OUT_W      = 4,
    parameter logic [IN_W-1:0] TRAIN_WORD = IN_W'(TMDS_CTRL_00)
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic [CHANNELS*IN_W-1:0]  i_pdata,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_train,
    input  logic                      i_oce,
    output logic [CHANNELS*OUT_W-1:0] o_sdata,
    output logic                      o_svalid,
    output logic                      o_underrun,
    input  logic                      i_underrun_clr
);

    localparam int unsigned BUF_W = buf_width(IN_W, OUT_W);
    localparam int unsigned CNT_W = cnt_width(IN_W, OUT_W);

    localparam logic [CNT_W-1:0] ROOM_MAX  = CNT_W'(BUF_W - IN_W);
    localparam logic [CNT_W-1:0] OUT_STEP  = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] IN_STEP   = CNT_W'(IN_W);
    localparam logic [BUF_W-1:0] WORD_MASK = BUF_W'({IN_W{1'b1}});

    logic                      rst_s;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic [CNT_W-1:0]          pos_c;
    logic                      room_c;
    logic                      load_c;
    logic                      drain_c;
    logic                      starve_c;
    logic [CHANNELS*OUT_W-1:0] slice_c;

    rst_bridge u_rst_bridge (
        .clk      (i_clk),
        .arst     (i_arst),
        .rst_sync (rst_s)
    );

    // Shared lockstep control: room, load/drain decisions and next fill level.
    always_comb begin
        room_c   = !rst_s && (cnt_q <= ROOM_MAX);
        o_ready  = room_c && !i_train;
        load_c   = (i_valid && o_ready) || (i_train && room_c);
        drain_c  = i_oce && (cnt_q >= OUT_STEP);
        starve_c = i_oce && (cnt_q < OUT_STEP);
        pos_c    = drain_c ? (cnt_q - OUT_STEP) : cnt_q;
        cnt_d    = pos_c + (load_c ? IN_STEP : CNT_W'(0));
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [BUF_W-1:0] buf_q;
        logic [BUF_W-1:0] buf_d;
        logic [BUF_W-1:0] shifted;
        logic [IN_W-1:0]  word;

        // Masked write so stale bits above the fill level never leak into a slice.
        always_comb begin
            word    = i_train ? TRAIN_WORD : i_pdata[c*IN_W +: IN_W];
            shifted = drain_c ? (buf_q >> OUT_W) : buf_q;
            buf_d   = shifted;
            if (load_c) begin
                buf_d = (shifted & ~(WORD_MASK << pos_c)) | (BUF_W'(word) << pos_c);
            end
        end

        always_ff @(posedge i_clk or posedge rst_s) begin
            if (rst_s) begin
                buf_q <= '0;
            end else begin
                buf_q <= buf_d;
            end
        end

        assign slice_c[c*OUT_W +: OUT_W] = buf_q[OUT_W-1:0];
    end

    // Output slice register: holds while downstream is idle, zeroes on starvation.
    always_ff @(posedge i_clk or posedge rst_s) begin
        if (rst_s) begin
            cnt_q      <= '0;
            o_sdata    <= '0;
            o_svalid   <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (drain_c) begin
                o_sdata  <= slice_c;
                o_svalid <= 1'b1;
            end else if (starve_c) begin
                o_sdata  <= '0;
                o_svalid <= 1'b0;
            end
            if (starve_c) begin
                o_underrun <= 1'b1;
            end else if (i_underrun_clr) begin
                o_underrun <= 1'b0;
            end
        end
    end

endmodule
